// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 32-step shift-add multiplier and restoring divider
// sharing one 64-bit working register, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; honours MTHI/MTLO
// RUN   | one multiply/divide step per clock, counter 0..31
// FIX   | apply result signs, write HI/LO, pulse done
module muldiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_write,
  input  logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [63:0] work;
  logic [31:0] operand;
  logic [31:0] a_raw;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] hi_r, lo_r;
  logic        done_r;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic        div_fits;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] mul_fixed;
  logic [31:0] fix_hi, fix_lo;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: work = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
  assign mul_next = {mul_sum, work[31:1]};

  // Divide: work = {remainder, dividend bits / quotient bits}.
  // When the trial subtraction succeeds the difference is below the divisor,
  // so its low 32 bits are exact.
  assign div_fits = {work[63:31]} >= {1'b0, operand};
  assign div_rem  = work[62:31] - operand;
  assign div_next = div_fits ? {div_rem, work[30:0], 1'b1} : {work[62:0], 1'b0};

  assign mul_fixed = neg_res ? -work : work;

  always_comb begin
    fix_hi = mul_fixed[63:32];
    fix_lo = mul_fixed[31:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = neg_rem ? -work[63:32] : work[63:32];
        fix_lo = neg_res ? -work[31:0]  : work[31:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (count == 5'd31) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 5'd0;
      work     <= 64'd0;
      operand  <= 32'd0;
      a_raw    <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count    <= 5'd0;
            a_raw    <= a;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op[1] && (b == 32'd0);
            if (op[1]) begin
              work    <= {32'd0, a_mag};
              operand <= b_mag;
            end else begin
              work    <= {32'd0, b_mag};
              operand <= a_mag;
            end
          end else begin
            // start takes priority over MTHI/MTLO in the same cycle
            if (hi_write) hi_r <= a;
            if (lo_write) lo_r <= a;
          end
        end
        S_RUN: begin
          work  <= is_div ? div_next : mul_next;
          count <= count + 5'd1;
        end
        S_FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic model of HI/LO, busy and done.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  muldiv_unit dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_write(hi_write), .lo_write(lo_write),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = 64'd0;
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else if (start) begin
        {p_hi, p_lo} = ref_result(op, a, b);
        m_left = 33;
      end else begin
        if (hi_write) m_hi = a;
        if (lo_write) m_lo = a;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en && reset_n) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Caller is between clock edges; start is held for exactly one edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #2;
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clock); n++; #1;
      if (done) break;
    end
    chk({name, " latency"}, n, 33);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    start_op(o, x, y);
    chk({name, " busy after accept"}, busy, 1'b1);
    wait_done(name);
    chk({name, " busy with done"}, busy, 1'b0);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      4: return -32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    #1 reset_n = 1'b0;
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    run("mult",      2'b00, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("multu",     2'b01, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE);
    run("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    run("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

    // Second start and MTHI while a MULTU is running must both be dropped.
    start_op(2'b01, 32'd3, 32'd5);
    repeat (9) @(posedge clock);
    #2;
    start = 1'b1; hi_write = 1'b1; a = 32'h0000_DEAD;
    @(posedge clock); #2;
    start = 1'b0; hi_write = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    chk("ignored done pulses", pulses, 1);
    chk("ignored hi", hi, 32'd0);
    chk("ignored lo", lo, 32'd15);
    hi_write = 1'b1; a = 32'h0000_DEAD;
    @(posedge clock); #1;
    hi_write = 1'b0;
    chk("mthi idle", hi, 32'h0000_DEAD);

    // Asynchronous reset in the middle of a divide.
    start_op(2'b10, 32'h0000_0100, 32'd3);
    repeat (15) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("midrun reset busy", busy, 1'b0);
    chk("midrun reset done", done, 1'b0);
    chk("midrun reset hi", hi, 32'd0);
    chk("midrun reset lo", lo, 32'd0);
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b1;
    run("after_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

    // Random traffic: starts, MTHI/MTLO, overlapping requests, back-to-back ops.
    repeat (4000) begin
      @(posedge clock); #2;
      start    = ($urandom % 4) == 0;
      op       = 2'($urandom);
      a        = pick();
      b        = pick();
      hi_write = ($urandom % 5) == 0;
      lo_write = ($urandom % 5) == 0;
    end
    @(posedge clock); #2;
    start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative HI/LO multiply/divide unit for the multi-cycle CPU. It sits directly downstream of the general-purpose register file: it consumes the two read ports (rs value, rt value) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It holds the architectural HI and LO registers, and exposes them for MFHI/MFLO. It is a 33-cycle shift/add multiplier and restoring divider, with a start/busy/done handshake towards the control unit.

## Interface
Parameters: none. Width fixed at 32.
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin operation `op` on `a`, `b`
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  32  rs value (multiplicand / dividend / MTHI-MTLO data)
- b  input  32  rt value (multiplier / divisor)
- hi_write  input  1  MTHI: HI <= a
- lo_write  input  1  MTLO: LO <= a
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse: HI/LO hold new result
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States:
  - IDLE: start -> RUN. Latch operand magnitudes and the result/remainder sign flags; clear the iteration counter.
  - RUN: 32 iterations, one per clock. Counter 0..31; counter == 31 -> FIX.
  - FIX: apply signs, write HI/LO, pulse done -> IDLE.
- Multiply (shift-add on |a|, |b|): 64-bit product, HI = [63:32], LO = [31:0].
  - MULT: negate the 64-bit product if sign(a) != sign(b).
  - MULTU: no sign handling.
- Divide (restoring, 1 quotient bit per cycle): LO = quotient, HI = remainder.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed -> LO = 0x80000000, HI = 0 (no trap).
- Divisor zero (DIV or DIVU):
  - LO = 0xFFFFFFFF, HI = a as latched (raw, not negated).
  - Still takes the full latency.
- MTHI/MTLO:
  - Honoured only in IDLE. Take effect on the clock edge they are sampled; the write is visible the next cycle.
  - Both may be asserted together.
- Ignored or dropped requests:
  - start while busy: ignored.
  - hi_write/lo_write while busy: ignored.
  - start and hi_write/lo_write in the same IDLE cycle: start wins, writes dropped.
- Operands:
  - a, b, op are sampled only at the accepting edge.
  - Later changes have no effect on the running operation.
- HI/LO stability:
  - Retain their previous values throughout RUN.
  - Change only at the FIX edge or on MTHI/MTLO.
  - The control unit may read them at any time.

## Timing
- Reset (reset_n low, asynchronous; immediate, mid-operation included):
  - State IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0.
  - Any in-flight operation is discarded.
  - The first rising edge with reset_n high and start = 1 is accepted.
- Accept and run:
  - E0 = the rising edge sampling start = 1 in IDLE; busy rises after E0.
  - E1..E32 = iterations; the state moves to FIX at E32.
- Completion at E33:
  - HI/LO updated, state IDLE, done = 1 for exactly one cycle (E33 to E34), busy = 0 in the same cycle as done.
  - Total latency: 33 clocks from the accepting edge to done. Identical for every op, including divide-by-zero.
- Back-to-back: start asserted while done = 1 is accepted at E34, so no dead cycle.
- done is registered; busy decodes directly from the state register.

## Test plan
- MULT a = 0xFFFFFFFF, b = 0x00000002:
  - hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
  - done exactly 33 clocks after the start edge; busy high for cycles 1..33.
- MULTU, same operands: hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV a = 0xFFFFFFF9 (-7), b = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU a = 100, b = 7: lo = 0x0000000E, hi = 0x00000002.
- Divide edge cases:
  - DIVU a = 0x1234, b = 0: lo = 0xFFFFFFFF, hi = 0x00001234, latency 33.
  - DIV a = 0x80000000, b = 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Ignored requests during a MULTU 3 x 5 run: a second start and hi_write (a = 0xDEAD) pulsed 10 cycles in.
  - Expect one done pulse only; hi = 0, lo = 15.
  - A subsequent IDLE hi_write with a = 0xDEAD then gives hi = 0xDEAD next cycle.
- Reset mid-run: reset_n low 16 cycles into a DIV.
  - busy, done, hi, lo all go to 0 immediately (no clock edge).
  - After release, MULTU 6 x 7 yields lo = 42, hi = 0, 33 clocks later.
